scm_1row_write_arbiter: RTL and testbench



---
 rtl/scm_ctrl_pkg.sv | 15 +
 rtl/scm_rr_arb.sv | 38 +++
 rtl/scm_1row_write_arbiter.sv | 125 ++++++++++++
 tb/tb_scm_1row_write_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/scm_ctrl_pkg.sv
// Shared types and helpers for the single-row SCM write arbiter.
package scm_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      SETTLE = 2'd2
   } scm_state_e;

   // Index width: at least one bit even for degenerate counts.
   function automatic int idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scm_rr_arb.sv
// Combinational round-robin picker: priority starts just above last_grant_i and wraps.
module scm_rr_arb #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDW-1:0]   last_grant_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDW-1:0]   idx_o,
   output logic             any_o
);

   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      // Upper segment first (above last grant), then wrap to the lower segment.
      for (int j = 0; j < N_REQ; j++) begin
         if (!found && req_i[j] && (j > int'(last_grant_i))) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IDW'(j);
         end
      end
      for (int j = 0; j < N_REQ; j++) begin
         if (!found && req_i[j] && (j <= int'(last_grant_i))) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IDW'(j);
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/scm_1row_write_arbiter.sv
// Round-robin write sequencer in front of the single-row latch SCM: one-cycle write
// pulse, then a settle window before the next grant; publishes valid/owner/count.
module scm_1row_write_arbiter
   import scm_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int N_REQ         = 4,
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16,
   localparam int IDW          = idw(N_REQ)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_REQ-1:0]                 req_valid_i,
   input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data_i,
   output logic [N_REQ-1:0]                 req_ready_o,
   output logic                             scm_we_o,
   output logic [DATA_WIDTH-1:0]            scm_wdata_o,
   output logic                             scm_re_o,
   output logic                             rdata_valid_o,
   output logic [IDW-1:0]                   owner_o,
   output logic [CNT_W-1:0]                 wr_count_o
);

   localparam int SCW = idw(SETTLE_CYCLES);

   scm_state_e            state_q, state_d;
   logic [IDW-1:0]        last_grant_q, last_grant_d;
   logic [IDW-1:0]        idx_q, idx_d;
   logic [IDW-1:0]        owner_q, owner_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [SCW-1:0]        settle_q, settle_d;
   logic                  valid_q, valid_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic [N_REQ-1:0]      gnt;
   logic [IDW-1:0]        win_idx;
   logic                  any_req;
   logic [N_REQ-1:0]      ready;
   logic                  we;

   scm_rr_arb #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_arb (
      .req_i        (req_valid_i),
      .last_grant_i (last_grant_q),
      .gnt_o        (gnt),
      .idx_o        (win_idx),
      .any_o        (any_req)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      idx_d        = idx_q;
      owner_d      = owner_q;
      wdata_d      = wdata_q;
      settle_d     = settle_q;
      valid_d      = valid_q;
      count_d      = count_q;
      ready        = '0;
      we           = 1'b0;
      case (state_q)
         IDLE: begin
            ready = gnt;
            // The grant always lands on an asserted valid, so any request is a handshake.
            if (any_req) begin
               wdata_d      = req_data_i[win_idx];
               idx_d        = win_idx;
               last_grant_d = win_idx;
               valid_d      = 1'b0;
               state_d      = WRITE;
            end
         end
         WRITE: begin
            we       = 1'b1;
            settle_d = SCW'(SETTLE_CYCLES - 1);
            state_d  = SETTLE;
         end
         SETTLE: begin
            if (settle_q == '0) begin
               owner_d = idx_q;
               count_d = count_q + CNT_W'(1);
               valid_d = 1'b1;
               state_d = IDLE;
            end else begin
               settle_d = settle_q - SCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= IDW'(N_REQ - 1);
         idx_q        <= '0;
         owner_q      <= '0;
         wdata_q      <= '0;
         settle_q     <= '0;
         valid_q      <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         idx_q        <= idx_d;
         owner_q      <= owner_d;
         wdata_q      <= wdata_d;
         settle_q     <= settle_d;
         valid_q      <= valid_d;
         count_q      <= count_d;
      end
   end

   assign req_ready_o   = rst ? '0 : ready;
   assign scm_we_o      = we;
   assign scm_wdata_o   = wdata_q;
   assign rdata_valid_o = valid_q;
   assign scm_re_o      = valid_q;
   assign owner_o       = owner_q;
   assign wr_count_o    = count_q;

endmodule

// File: tb/tb_scm_1row_write_arbiter.sv
// Bench for the SCM write arbiter: two instances (default, and settle=3 / 4-bit counter)
// checked every cycle against a transaction-level model of grants and write completions.
module tb_scm_1row_write_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst0, rst1;
   logic [N-1:0]       vld0, vld1;
   logic [N-1:0][DW-1:0] dat0, dat1;
   logic [N-1:0]       rdy0, rdy1;
   logic               we0, we1, re0, re1, rv0, rv1;
   logic [DW-1:0]      wd0, wd1;
   logic [1:0]         own0, own1;
   logic [15:0]        cnt0;
   logic [3:0]         cnt1;

   scm_1row_write_arbiter dut0 (
      .clk(clk), .rst(rst0), .req_valid_i(vld0), .req_data_i(dat0), .req_ready_o(rdy0),
      .scm_we_o(we0), .scm_wdata_o(wd0), .scm_re_o(re0), .rdata_valid_o(rv0),
      .owner_o(own0), .wr_count_o(cnt0)
   );

   scm_1row_write_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .SETTLE_CYCLES(3), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst1), .req_valid_i(vld1), .req_data_i(dat1), .req_ready_o(rdy1),
      .scm_we_o(we1), .scm_wdata_o(wd1), .scm_re_o(re1), .rdata_valid_o(rv1),
      .owner_o(own1), .wr_count_o(cnt1)
   );

   int ncmp = 0, nfail = 0;

   // Model: a write occupies the port for 1+settle cycles after its handshake, then commits.
   int          settle[2] = '{1, 3};
   int          cmod[2]   = '{65536, 16};
   int          busy[2], lg[2], widx[2], mcnt[2], mown[2];
   bit          mval[2];
   logic [31:0] mlast[2];
   bit [N-1:0]  pend[2];
   logic [31:0] pdat[2][N];
   bit          rrst[2], hold_all[2], hs[2];
   int          rnd_pct[2], hw[2];

   logic [N-1:0] o_rdy[2];
   logic         o_we[2], o_rv[2], o_re[2];
   logic [31:0]  o_wd[2];
   logic [1:0]   o_own[2];
   logic [15:0]  o_cnt[2];

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      ncmp++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, o, e);
      end
   endtask

   function automatic int winner(input int d);
      for (int k = 1; k <= N; k++) begin
         int w;
         w = (lg[d] + k) % N;
         if (pend[d][w]) return w;
      end
      return -1;
   endfunction

   task automatic model_reset(input int d);
      busy[d] = 0; lg[d] = N - 1; mcnt[d] = 0; mown[d] = 0; mval[d] = 1'b0; mlast[d] = '0;
   endtask

   task automatic add_req(input int d, input int w, input logic [31:0] v);
      if (!pend[d][w]) begin
         pend[d][w] = 1'b1;
         pdat[d][w] = v;
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < N; w++) begin
            if (hold_all[d] || (rnd_pct[d] > 0 && int'($urandom_range(99)) < rnd_pct[d]))
               add_req(d, w, $urandom);
         end
      end
      rst0 = rrst[0]; rst1 = rrst[1];
      vld0 = pend[0]; vld1 = pend[1];
      for (int w = 0; w < N; w++) begin
         dat0[w] = pdat[0][w];
         dat1[w] = pdat[1][w];
      end
      #1;
      o_rdy[0] = rdy0; o_rdy[1] = rdy1;
      o_we[0]  = we0;  o_we[1]  = we1;
      o_rv[0]  = rv0;  o_rv[1]  = rv1;
      o_re[0]  = re0;  o_re[1]  = re1;
      o_wd[0]  = wd0;  o_wd[1]  = wd1;
      o_own[0] = own0; o_own[1] = own1;
      o_cnt[0] = cnt0; o_cnt[1] = {12'b0, cnt1};
      for (int d = 0; d < 2; d++) begin
         int w;
         logic [N-1:0] er;
         w  = winner(d);
         er = '0;
         if (!rrst[d] && busy[d] == 0 && w >= 0) er[w] = 1'b1;
         hs[d] = (er != '0);
         hw[d] = w;
         chk("ready",  o_rdy[d], er);
         chk("we",     o_we[d],  busy[d] == 1 + settle[d]);
         chk("wdata",  o_wd[d],  mlast[d]);
         chk("rvalid", o_rv[d],  mval[d]);
         chk("re",     o_re[d],  mval[d]);
         chk("owner",  o_own[d], mown[d]);
         chk("count",  o_cnt[d], mcnt[d] % cmod[d]);
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rrst[d]) model_reset(d);
         else begin
            if (busy[d] > 0) begin
               busy[d]--;
               if (busy[d] == 0) begin
                  mcnt[d]++;
                  mown[d] = widx[d];
                  mval[d] = 1'b1;
               end
            end
            if (hs[d]) begin
               busy[d]        = 1 + settle[d];
               widx[d]        = hw[d];
               mlast[d]       = pdat[d][hw[d]];
               lg[d]          = hw[d];
               mval[d]        = 1'b0;
               pend[d][hw[d]] = 1'b0;
            end
         end
      end
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      while ((pend[d] != '0 || busy[d] != 0) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) chk("drain_timeout", 0, 1);
   endtask

   initial begin
      int n;
      rst0 = 1'b1; rst1 = 1'b1; vld0 = '0; vld1 = '0; dat0 = '0; dat1 = '0;
      for (int d = 0; d < 2; d++) begin
         pend[d] = '0; hold_all[d] = 1'b0; rnd_pct[d] = 0; rrst[d] = 1'b1;
         for (int w = 0; w < N; w++) pdat[d][w] = '0;
         model_reset(d);
      end
      repeat (2) @(posedge clk);

      // Reset state, with a pending request that must not be granted during reset.
      add_req(0, 1, 32'h1111_1111);
      step();
      pend[0] = '0;
      rrst[0] = 1'b0; rrst[1] = 1'b0;

      // Single write from writer 2.
      add_req(0, 2, 32'hDEAD_BEEF);
      step(); chk("sw_ready", o_rdy[0], 4'b0100);
      step(); chk("sw_we", o_we[0], 1); chk("sw_wdata", o_wd[0], 32'hDEAD_BEEF);
      step(); chk("sw_settle_rv", o_rv[0], 0);
      step(); chk("sw_rv", o_rv[0], 1); chk("sw_owner", o_own[0], 2); chk("sw_cnt", o_cnt[0], 1);

      // Longer settle on the second instance: valid rises 5 cycles after the handshake.
      add_req(1, 0, 32'h5);
      step(); chk("ls_ready", o_rdy[1], 4'b0001);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("ls_rv", o_rv[1], i == 5);
      end
      chk("ls_wdata", o_wd[1], 32'h5);

      // Fairness: all writers request continuously.
      hold_all[0] = 1'b1;
      repeat (15) step();
      hold_all[0] = 1'b0;
      drain(0);

      // No grant while a write is in flight.
      add_req(0, 0, $urandom);
      step(); chk("nm_hs", o_rdy[0], 4'b0001);
      add_req(0, 1, $urandom);
      step(); chk("nm_write_rdy", o_rdy[0], 4'b0000);
      step(); chk("nm_settle_rdy", o_rdy[0], 4'b0000);
      step(); chk("nm_grant", o_rdy[0], 4'b0010);
      drain(0);

      // Reset asserted during the WRITE cycle.
      add_req(0, 3, $urandom);
      step(); chk("rm_hs", o_rdy[0], 4'b1000);
      rrst[0] = 1'b1;
      step();
      rrst[0] = 1'b0;
      add_req(0, 0, $urandom);
      add_req(0, 2, $urandom);
      step();
      chk("rm_we", o_we[0], 0); chk("rm_rv", o_rv[0], 0); chk("rm_cnt", o_cnt[0], 0);
      chk("rm_owner", o_own[0], 0); chk("rm_wdata", o_wd[0], 0); chk("rm_grant", o_rdy[0], 4'b0001);
      drain(0);

      // Counter wrap on the 4-bit instance: 17 writes give 1.
      hold_all[1] = 1'b1;
      n = 0;
      while (mcnt[1] < 17 && n < 200) begin
         step();
         n++;
      end
      hold_all[1] = 1'b0;
      if (n >= 200) chk("wrap_timeout", 0, 1);
      #1 chk("wrap_cnt", cnt1, 1);
      drain(1);

      // Random traffic on both instances.
      rnd_pct[0] = 25; rnd_pct[1] = 40;
      repeat (400) step();
      rnd_pct[0] = 0; rnd_pct[1] = 0;
      drain(0);
      drain(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
